regex_stream_matcher: RTL and testbench
=======================================

// Module: regex_stream_matcher
// PURPOSE
//  Multi-channel, runtime-programmable DFA regex matcher. Processes one character per cycle from
//  2**CHAN_W interleaved streams against one shared DFA, and keeps a per-channel state and byte offset.
//  Emits a match event (channel, offset, state) through a valid/ready output.
//  Sits between the packet parser and the host result queue. Supports context save/restore.
// PARAMETERS
//  CHAN_W   2   channel id width; 2**CHAN_W channels
//  STATE_W  8   DFA state width; 2**STATE_W states
//  CLASS_W  4   character-class width; 2**CLASS_W classes
//  OFFS_W  16   per-channel byte offset width, saturating
//  CNT_W   32   match counter width, saturating
// PORTS
//  clk        in   1        clock
//  rst        in   1        reset, synchronous, active-high
//  cfg_we     in   1        table write strobe
//  cfg_sel    in   2        0 = class map, 1 = transition, 2 = accept, 3 = ignored
//  cfg_addr   in   STATE_W+CLASS_W  class map: char in [7:0]; trans: {state, class}; accept: state in [STATE_W-1:0]
//  cfg_data   in   STATE_W  class map: [CLASS_W-1:0]; trans: next state; accept: bit 0
//  ctx_we     in   1        overwrite state of ctx_chan with ctx_state; offset unchanged
//  ctx_chan   in   CHAN_W   context channel select
//  ctx_state  in   STATE_W  state to load
//  ctx_rd     out  STATE_W  combinational current state of ctx_chan
//  in_valid   in   1        character available
//  in_ready   out  1        character accepted when in_valid & in_ready
//  in_chan    in   CHAN_W   channel of character
//  in_char    in   8        character
//  in_last    in   1        last character of packet on in_chan
//  m_valid    out  1        match event pending
//  m_ready    in   1        consumer takes event
//  m_chan / m_offset / m_state  out  CHAN_W / OFFS_W / STATE_W   event fields
//  match_count  out  CNT_W  total match events since reset
// BEHAVIOUR
//  - Reset: all channel states = START_STATE (0), offsets = 0, m_valid = 0, m_* = 0, match_count = 0,
//    accept bits = 0. Class map and transition table are not reset; they are undefined until written.
//  - in_ready = !rst & !cfg_we & !ctx_we & !(m_valid & !m_ready). Config and context writes take
//    priority over data; a char presented in the same cycle is held, not dropped.
//  - Accept cycle t: cls = cmap[in_char]; nxt = trans[{state[in_chan], cls}]; state[in_chan] <= nxt.
//    Lookup is combinational from the state file, so back-to-back chars on one channel need no bubble.
//  - Offset: the char's offset is offs[in_chan]; offs[in_chan] <= offs+1, saturating at all-ones.
//  - in_last: after the update, state[in_chan] <= START_STATE and offs[in_chan] <= 0. A match on the
//    last char is still reported.
//  - If accept[nxt], at t+1: m_valid = 1, m_chan = in_chan, m_offset = char offset, m_state = nxt.
//    match_count += 1 at t+1, saturating. No match means no event.
//  - Output register holds its fields stable while m_valid & !m_ready. It clears when m_ready and no
//    new event arrives. It reloads the same cycle when m_ready and a new event arrive (full rate).
//  - cfg write lands at posedge and is visible to a char accepted the next cycle.
//    Writes with cfg_sel = 3 are ignored.
//  - ctx_we: state[ctx_chan] <= ctx_state. Matches are not evaluated for a loaded state.
//  - rst asserted mid-stream: the pending event is discarded, states and offsets clear; table contents
//    are kept except accept bits.
// STRUCTURE
//  - regex_pkg: CFG_CMAP/CFG_TRANS/CFG_ACCEPT encodings, START_STATE, event struct widths.
//  - Sub-module regex_dfa_tables: class map, transition table, accept vector, one write port and
//    combinational read. Top holds the state/offset files, handshake, output register and counter.
// TESTING
//  - Program "ab" DFA: a -> class 1, b -> class 2; (0,1)->1, (1,1)->1, (1,2)->2, (2,1)->1, else 0;
//    accept[2] = 1. Ch0 sends "xab" -> one event {chan 0, offset 2, state 2}, match_count = 1.
//  - Interleave ch1 'a', ch2 'a', ch1 'b', ch2 'b' -> events {1,1,2}, then {2,1,2}; no cross-channel
//    bleed.
//  - m_ready = 0 with "abab" on ch0 -> first event held stable, in_ready drops; release m_ready -> both
//    events arrive in order with offsets 1 and 3.
//  - ch0 'a' with in_last, then 'b' -> no match; the next packet starts at offset 0.
//  - ctx_we loads state 1 into ch3 with in_valid high the same cycle -> in_ready = 0 that cycle;
//    next 'b' on ch3 -> event {3,0,2}; ctx_rd reads 1 before the 'b'.
//  - 70000 non-matching chars on ch0 -> offset saturates at 65535; then "ab" -> event offset 65535.

Source files
------------

// File: rtl/regex_stream_matcher_pkg.sv
// Shared encodings and default widths for the multi-channel DFA regex matcher.
package regex_stream_matcher_pkg;

    localparam int unsigned CHAN_W_DEF  = 2;
    localparam int unsigned STATE_W_DEF = 8;
    localparam int unsigned CLASS_W_DEF = 4;
    localparam int unsigned OFFS_W_DEF  = 16;
    localparam int unsigned CNT_W_DEF   = 32;

    // Every channel begins a packet (and recovers from reset) in DFA state 0.
    localparam int unsigned START_STATE = 0;

    // Which table a configuration write targets.
    typedef enum logic [1:0] {
        CFG_CMAP   = 2'd0,
        CFG_TRANS  = 2'd1,
        CFG_ACCEPT = 2'd2,
        CFG_NONE   = 2'd3
    } cfg_sel_e;

endpackage

// File: rtl/regex_stream_matcher_if.sv
// Character input stream and match-event output stream of the matcher.
// master = upstream/host side, slave = the matcher.
interface regex_stream_matcher_if #(
    parameter int unsigned CHAN_W  = 2,
    parameter int unsigned STATE_W = 8,
    parameter int unsigned OFFS_W  = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [CHAN_W-1:0]  in_chan;
    logic [7:0]         in_char;
    logic               in_last;

    logic               m_valid;
    logic               m_ready;
    logic [CHAN_W-1:0]  m_chan;
    logic [OFFS_W-1:0]  m_offset;
    logic [STATE_W-1:0] m_state;

    modport master (
        output in_valid, in_chan, in_char, in_last, m_ready,
        input  in_ready, m_valid, m_chan, m_offset, m_state
    );

    modport slave (
        input  in_valid, in_chan, in_char, in_last, m_ready,
        output in_ready, m_valid, m_chan, m_offset, m_state
    );
endinterface

// File: rtl/regex_stream_matcher_dfa_tables.sv
// DFA tables: character-class map, transition table and accept vector.
// One shared write port, fully combinational lookup path char -> class -> next -> accept.
module regex_dfa_tables
    import regex_stream_matcher_pkg::*;
#(
    parameter int unsigned STATE_W = STATE_W_DEF,
    parameter int unsigned CLASS_W = CLASS_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_we,
    input  logic [1:0]                 cfg_sel,
    input  logic [STATE_W+CLASS_W-1:0] cfg_addr,
    input  logic [STATE_W-1:0]         cfg_data,
    input  logic [7:0]                 rd_char,
    input  logic [STATE_W-1:0]         rd_state,
    output logic [STATE_W-1:0]         rd_next,
    output logic                       rd_accept
);

    logic [CLASS_W-1:0]  cmap   [256];
    logic [STATE_W-1:0]  trans  [2**(STATE_W+CLASS_W)];
    logic [2**STATE_W-1:0] accept;
    logic [CLASS_W-1:0]  rd_class;

    // Class map and transition table writes.
    // NOTE: these arrays carry no reset -- they are RAM-like storage that software must program
    // before use, and resetting them would force them into flops; they also survive a mid-stream reset.
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            // NOTE: non-blocking assignments for all clocked state so every reader sees pre-edge values.
            case (cfg_sel_e'(cfg_sel))
                CFG_CMAP:  cmap[cfg_addr[7:0]] <= cfg_data[CLASS_W-1:0];
                CFG_TRANS: trans[cfg_addr]     <= cfg_data;
                default:   ;
            endcase
        end
    end

    // Accept bits are small and are cleared by reset so no stale state can match.
    always_ff @(posedge clk) begin
        if (rst) begin
            accept <= '0;
        end else if (cfg_we && (cfg_sel_e'(cfg_sel) == CFG_ACCEPT)) begin
            accept[cfg_addr[STATE_W-1:0]] <= cfg_data[0];
        end
    end

    assign rd_class  = cmap[rd_char];
    assign rd_next   = trans[{rd_state, rd_class}];
    assign rd_accept = accept[rd_next];

endmodule

// File: rtl/regex_stream_matcher.sv
// Multi-channel runtime-programmable DFA matcher: one char per cycle from interleaved channels,
// per-channel state/offset files, registered match-event output with full-rate handshake.
module regex_stream_matcher
    import regex_stream_matcher_pkg::*;
#(
    parameter int unsigned CHAN_W  = CHAN_W_DEF,
    parameter int unsigned STATE_W = STATE_W_DEF,
    parameter int unsigned CLASS_W = CLASS_W_DEF,
    parameter int unsigned OFFS_W  = OFFS_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_we,
    input  logic [1:0]                 cfg_sel,
    input  logic [STATE_W+CLASS_W-1:0] cfg_addr,
    input  logic [STATE_W-1:0]         cfg_data,
    input  logic                       ctx_we,
    input  logic [CHAN_W-1:0]          ctx_chan,
    input  logic [STATE_W-1:0]         ctx_state,
    output logic [STATE_W-1:0]         ctx_rd,
    regex_stream_matcher_if.slave      bus,
    output logic [CNT_W-1:0]           match_count
);

    localparam int unsigned NCHAN = 2**CHAN_W;

    typedef struct packed {
        logic [CHAN_W-1:0]  chan;
        logic [OFFS_W-1:0]  offset;
        logic [STATE_W-1:0] state;
    } match_evt_t;

    logic [STATE_W-1:0] states [NCHAN];
    logic [OFFS_W-1:0]  offs   [NCHAN];

    match_evt_t         evt_q;
    logic               evt_valid;
    logic [CNT_W-1:0]   count_q;

    logic [STATE_W-1:0] cur_state;
    logic [OFFS_W-1:0]  cur_offs;
    logic [STATE_W-1:0] nxt_state;
    logic               nxt_accept;
    logic [STATE_W-1:0] upd_state;
    logic [OFFS_W-1:0]  upd_offs;
    logic               fire;
    logic               hit;

    regex_dfa_tables #(
        .STATE_W (STATE_W),
        .CLASS_W (CLASS_W)
    ) u_tables (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .rd_char   (bus.in_char),
        .rd_state  (cur_state),
        .rd_next   (nxt_state),
        .rd_accept (nxt_accept)
    );

    // Config/context writes win over data; a stalled output register also blocks input.
    assign bus.in_ready = !rst && !cfg_we && !ctx_we && !(evt_valid && !bus.m_ready);
    assign fire         = bus.in_valid && bus.in_ready;
    assign hit          = fire && nxt_accept;

    assign cur_state = states[bus.in_chan];
    assign cur_offs  = offs[bus.in_chan];
    assign ctx_rd    = states[ctx_chan];

    // Post-char state and offset for the active channel: saturating offset, restart on last char.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        upd_state = nxt_state;
        upd_offs  = (cur_offs == '1) ? cur_offs : cur_offs + OFFS_W'(1);
        if (bus.in_last) begin
            upd_state = STATE_W'(START_STATE);
            upd_offs  = '0;
        end
    end

    // Per-channel state and offset files; context load and char acceptance are mutually exclusive.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCHAN; i++) begin
                states[i] <= STATE_W'(START_STATE);
                offs[i]   <= '0;
            end
        end else begin
            if (ctx_we) begin
                states[ctx_chan] <= ctx_state;
            end
            if (fire) begin
                states[bus.in_chan] <= upd_state;
                offs[bus.in_chan]   <= upd_offs;
            end
        end
    end

    // Output event register and saturating match counter; reloads in the same cycle it drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid <= 1'b0;
            evt_q     <= '0;
            count_q   <= '0;
        end else if (hit) begin
            evt_valid <= 1'b1;
            evt_q     <= '{chan: bus.in_chan, offset: cur_offs, state: nxt_state};
            if (count_q != '1) begin
                count_q <= count_q + CNT_W'(1);
            end
        end else if (bus.m_ready) begin
            evt_valid <= 1'b0;
            evt_q     <= '0;
        end
    end

    assign bus.m_valid  = evt_valid;
    assign bus.m_chan   = evt_q.chan;
    assign bus.m_offset = evt_q.offset;
    assign bus.m_state  = evt_q.state;
    assign match_count  = count_q;

endmodule

// File: tb/tb_regex_stream_matcher.sv
// Self-checking bench for regex_stream_matcher: "ab" DFA, table-driven char vectors with a
// scoreboard of expected match events, plus hand sequences for stall, context load, reset, saturation.
module tb_regex_stream_matcher;

    localparam int unsigned CHAN_W  = 2;
    localparam int unsigned STATE_W = 8;
    localparam int unsigned CLASS_W = 4;
    localparam int unsigned OFFS_W  = 16;
    localparam int unsigned CNT_W   = 32;

    localparam logic [7:0] C_A = 8'h61;
    localparam logic [7:0] C_B = 8'h62;
    localparam logic [7:0] C_X = 8'h78;

    typedef struct {
        logic [CHAN_W-1:0]  chan;
        logic [OFFS_W-1:0]  offs;
        logic [STATE_W-1:0] state;
    } exp_evt_t;

    typedef struct {
        logic [CHAN_W-1:0]  chan;
        logic [7:0]         ch;
        logic               last;
        logic               hit;
        logic [OFFS_W-1:0]  offs;
        logic [STATE_W-1:0] after;
    } vec_t;

    logic                       clk;
    logic                       rst;
    logic                       cfg_we;
    logic [1:0]                 cfg_sel;
    logic [STATE_W+CLASS_W-1:0] cfg_addr;
    logic [STATE_W-1:0]         cfg_data;
    logic                       ctx_we;
    logic [CHAN_W-1:0]          ctx_chan;
    logic [STATE_W-1:0]         ctx_state;
    logic [STATE_W-1:0]         ctx_rd;
    logic [CNT_W-1:0]           match_count;

    int n_cmp = 0;
    int n_err = 0;
    exp_evt_t sb[$];
    exp_evt_t mon_evt;
    vec_t vecs[15];

    regex_stream_matcher_if #(.CHAN_W(CHAN_W), .STATE_W(STATE_W), .OFFS_W(OFFS_W)) bus ();

    regex_stream_matcher #(
        .CHAN_W (CHAN_W), .STATE_W (STATE_W), .CLASS_W (CLASS_W), .OFFS_W (OFFS_W), .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_sel     (cfg_sel),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .ctx_we      (ctx_we),
        .ctx_chan    (ctx_chan),
        .ctx_state   (ctx_state),
        .ctx_rd      (ctx_rd),
        .bus         (bus),
        .match_count (match_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference "ab" DFA transition function.
    function automatic logic [STATE_W-1:0] dfa_next(input int s, input int c);
        if (c == 1 && s <= 2) return 1;
        if (s == 1 && c == 2) return 2;
        return 0;
    endfunction

    // Scoreboard: every handshake of a match event pops and compares one expectation.
    always @(negedge clk) begin
        if (!rst && bus.m_valid && bus.m_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_event: got chan %0d offset %0d state %0d, none expected",
                         bus.m_chan, bus.m_offset, bus.m_state);
            end else begin
                mon_evt = sb.pop_front();
                check("evt_chan",   64'(bus.m_chan),   64'(mon_evt.chan));
                check("evt_offset", 64'(bus.m_offset), 64'(mon_evt.offs));
                check("evt_state",  64'(bus.m_state),  64'(mon_evt.state));
            end
        end
    end

    task automatic cfg_write(input logic [1:0] sel, input int addr, input int data);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_addr = (STATE_W + CLASS_W)'(addr);
        cfg_data = STATE_W'(data);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    // Present one char, push its expected event, wait (bounded) for acceptance.
    task automatic send_char(input logic [CHAN_W-1:0] chan, input logic [7:0] ch, input logic last,
                             input logic hit, input logic [OFFS_W-1:0] offs);
        bit got;
        bus.in_valid = 1'b1;
        bus.in_chan  = chan;
        bus.in_char  = ch;
        bus.in_last  = last;
        if (hit) sb.push_back('{chan: chan, offs: offs, state: STATE_W'(2)});
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("in_ready_timeout", 64'(got), 64'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 50; k++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("drain_empty", 64'(sb.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{chan: 2'd0, ch: C_X, last: 1'b0, hit: 1'b0, offs: 16'd0, after: 8'd0};
        vecs[1]  = '{chan: 2'd0, ch: C_A, last: 1'b0, hit: 1'b0, offs: 16'd1, after: 8'd1};
        vecs[2]  = '{chan: 2'd0, ch: C_B, last: 1'b0, hit: 1'b1, offs: 16'd2, after: 8'd2};
        vecs[3]  = '{chan: 2'd1, ch: C_A, last: 1'b0, hit: 1'b0, offs: 16'd0, after: 8'd1};
        vecs[4]  = '{chan: 2'd2, ch: C_A, last: 1'b0, hit: 1'b0, offs: 16'd0, after: 8'd1};
        vecs[5]  = '{chan: 2'd1, ch: C_B, last: 1'b0, hit: 1'b1, offs: 16'd1, after: 8'd2};
        vecs[6]  = '{chan: 2'd2, ch: C_B, last: 1'b0, hit: 1'b1, offs: 16'd1, after: 8'd2};
        vecs[7]  = '{chan: 2'd0, ch: C_A, last: 1'b1, hit: 1'b0, offs: 16'd3, after: 8'd0};
        vecs[8]  = '{chan: 2'd0, ch: C_B, last: 1'b0, hit: 1'b0, offs: 16'd0, after: 8'd0};
        vecs[9]  = '{chan: 2'd0, ch: C_A, last: 1'b0, hit: 1'b0, offs: 16'd1, after: 8'd1};
        vecs[10] = '{chan: 2'd0, ch: C_B, last: 1'b0, hit: 1'b1, offs: 16'd2, after: 8'd2};
        vecs[11] = '{chan: 2'd1, ch: C_A, last: 1'b0, hit: 1'b0, offs: 16'd2, after: 8'd1};
        vecs[12] = '{chan: 2'd1, ch: C_B, last: 1'b1, hit: 1'b1, offs: 16'd3, after: 8'd0};
        vecs[13] = '{chan: 2'd1, ch: C_A, last: 1'b0, hit: 1'b0, offs: 16'd0, after: 8'd1};
        vecs[14] = '{chan: 2'd1, ch: C_B, last: 1'b0, hit: 1'b1, offs: 16'd1, after: 8'd2};

        rst = 1'b1;
        cfg_we = 1'b0; cfg_sel = 2'd0; cfg_addr = '0; cfg_data = '0;
        ctx_we = 1'b0; ctx_chan = '0; ctx_state = '0;
        bus.in_valid = 1'b0; bus.in_chan = '0; bus.in_char = '0; bus.in_last = 1'b0;
        bus.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state.
        check("rst_m_valid",     64'(bus.m_valid),  64'(0));
        check("rst_m_offset",    64'(bus.m_offset), 64'(0));
        check("rst_match_count", 64'(match_count),  64'(0));
        check("rst_in_ready",    64'(bus.in_ready), 64'(0));
        check("rst_ctx_rd",      64'(ctx_rd),       64'(0));
        rst = 1'b0;
        #1;
        check("in_ready_idle", 64'(bus.in_ready), 64'(1));

        // Program the "ab" DFA.
        for (int c = 0; c < 256; c++)
            cfg_write(2'd0, c, (c == int'(C_A)) ? 1 : (c == int'(C_B)) ? 2 : 0);
        for (int s = 0; s < 4; s++)
            for (int c = 0; c < 16; c++)
                cfg_write(2'd1, (s << CLASS_W) | c, int'(dfa_next(s, c)));
        cfg_write(2'd2, 2, 1);

        // Ignored cfg_sel=3 write aimed at accept[2], with a char held the same cycle.
        cfg_we = 1'b1; cfg_sel = 2'd3; cfg_addr = 12'd2; cfg_data = 8'd0;
        bus.in_valid = 1'b1; bus.in_chan = 2'd0; bus.in_char = C_X; bus.in_last = 1'b1;
        @(negedge clk);
        check("in_ready_during_cfg", 64'(bus.in_ready), 64'(0));
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        @(negedge clk);
        check("in_ready_after_cfg", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0; bus.in_last = 1'b0;

        // Table-driven char vectors.
        foreach (vecs[i]) begin
            send_char(vecs[i].chan, vecs[i].ch, vecs[i].last, vecs[i].hit, vecs[i].offs);
            ctx_chan = vecs[i].chan;
            #1;
            check($sformatf("vec%0d_state", i), 64'(ctx_rd), 64'(vecs[i].after));
        end
        drain();
        check("count_after_vectors", 64'(match_count), 64'(6));

        // Backpressure: "abab" on a fresh ch0 with m_ready low.
        send_char(2'd0, C_X, 1'b1, 1'b0, 16'd0);
        bus.m_ready = 1'b0;
        send_char(2'd0, C_A, 1'b0, 1'b0, 16'd0);
        send_char(2'd0, C_B, 1'b0, 1'b1, 16'd1);
        bus.in_valid = 1'b1; bus.in_chan = 2'd0; bus.in_char = C_A; bus.in_last = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(bus.in_ready), 64'(0));
            check("stall_m_valid",  64'(bus.m_valid),  64'(1));
            check("stall_m_offset", 64'(bus.m_offset), 64'(1));
            check("stall_m_state",  64'(bus.m_state),  64'(2));
        end
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        send_char(2'd0, C_B, 1'b0, 1'b1, 16'd3);
        drain();

        // Context load on ch3 collides with a held 'b' on ch3.
        ctx_we = 1'b1; ctx_chan = 2'd3; ctx_state = 8'd1;
        bus.in_valid = 1'b1; bus.in_chan = 2'd3; bus.in_char = C_B; bus.in_last = 1'b0;
        sb.push_back('{chan: 2'd3, offs: 16'd0, state: 8'd2});
        @(negedge clk);
        check("ctx_in_ready", 64'(bus.in_ready), 64'(0));
        @(posedge clk);
        #1;
        ctx_we = 1'b0;
        check("ctx_rd_loaded", 64'(ctx_rd), 64'(1));
        @(negedge clk);
        check("ctx_char_ready", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        drain();
        check("count_before_rst", 64'(match_count), 64'(9));

        // Mid-stream reset discards a pending event and clears accept bits only.
        bus.m_ready = 1'b0;
        send_char(2'd2, C_A, 1'b0, 1'b0, 16'd0);
        send_char(2'd2, C_B, 1'b0, 1'b0, 16'd0);
        check("pending_before_rst", 64'(bus.m_valid), 64'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.m_ready = 1'b1;
        ctx_chan = 2'd2;
        #1;
        check("midrst_m_valid", 64'(bus.m_valid),  64'(0));
        check("midrst_count",   64'(match_count),  64'(0));
        check("midrst_state",   64'(ctx_rd),       64'(0));
        ctx_chan = 2'd0;
        send_char(2'd0, C_A, 1'b0, 1'b0, 16'd0);
        check("tables_kept", 64'(ctx_rd), 64'(1));
        send_char(2'd0, C_B, 1'b0, 1'b0, 16'd0);
        check("accept_cleared_state", 64'(ctx_rd), 64'(2));
        drain();
        cfg_write(2'd2, 2, 1);
        send_char(2'd0, C_X, 1'b1, 1'b0, 16'd0);
        send_char(2'd0, C_A, 1'b0, 1'b0, 16'd0);
        send_char(2'd0, C_B, 1'b0, 1'b1, 16'd1);
        drain();
        check("count_after_rst", 64'(match_count), 64'(1));

        // Offset saturation: 70000 non-matching chars, then "ab".
        send_char(2'd0, C_X, 1'b1, 1'b0, 16'd0);
        bus.in_valid = 1'b1; bus.in_chan = 2'd0; bus.in_char = C_X; bus.in_last = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        send_char(2'd0, C_A, 1'b0, 1'b0, 16'd0);
        send_char(2'd0, C_B, 1'b0, 1'b1, 16'hFFFF);
        drain();
        check("count_final", 64'(match_count), 64'(2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
